// File: rtl/sum_accumulator_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sum_accumulator_pkg
// Brief    : Shared types, default parameters and the saturating adder helper
//            for the sum_accumulator block.
// Revision : 1.0 - initial release
// ============================================================================
package sum_accumulator_pkg;

  // Batch controller states: IDLE (cnt=0), ACCUM (partial batch), HOLD (result waiting)
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int unsigned C_DATA_W_DEF  = 16;
  localparam int unsigned C_ACC_W_DEF   = 18;
  localparam int unsigned C_COUNT_N_DEF = 8;

  // Working width of the saturating helper; callers zero-extend into it and
  // truncate the result back to their accumulator width.
  localparam int unsigned C_SAT_W = 64;

  typedef struct packed {
    logic               ovf;
    logic [C_SAT_W-1:0] value;
  } sat_res_t;

  // Unsigned add that clamps at 2^acc_w-1 and reports whether it clamped.
  function automatic sat_res_t sat_add(input logic [C_SAT_W-1:0] acc,
                                       input logic [C_SAT_W-1:0] data,
                                       input int unsigned        acc_w);
    logic [C_SAT_W:0] sum;
    logic [C_SAT_W:0] max_val;
    sat_res_t         res;
    sum     = {1'b0, acc} + {1'b0, data};
    max_val = (65'd1 << acc_w) - 65'd1;
    if (sum > max_val) begin
      res.ovf   = 1'b1;
      res.value = max_val[C_SAT_W-1:0];
    end else begin
      res.ovf   = 1'b0;
      res.value = sum[C_SAT_W-1:0];
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sum_accumulator_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sum_accumulator_ctrl
// Brief    : Batch FSM, sample counter and valid/ready handshake logic.
//            Emits one-hot-ish datapath strobes for the accumulator in the top.
// Revision : 1.0 - initial release
// ============================================================================
module sum_accumulator_ctrl
  import sum_accumulator_pkg::*;
#(
  parameter int unsigned COUNT_N = C_COUNT_N_DEF,
  parameter int unsigned CNT_W   = $clog2(C_COUNT_N_DEF + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             flush,
  input  logic             out_ready,
  output logic             in_ready,
  output logic             out_valid,
  output logic             start,     // acc <= in_data (first sample of a batch)
  output logic             accum,     // acc <= acc + in_data
  output logic             close,     // batch completes this cycle; latch outputs
  output logic             clear,     // result consumed with no new sample
  output logic [CNT_W-1:0] cnt_next
);

  localparam logic             c_single = (COUNT_N == 1);
  localparam logic [CNT_W-1:0] c_full   = CNT_W'(COUNT_N);
  localparam logic [CNT_W-1:0] c_one    = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_out_valid;
  logic             w_in_fire;
  logic             w_out_fire;

  // A waiting result blocks input unless the sink takes it the same cycle.
  assign in_ready   = (r_state != HOLD) | out_ready;
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = r_out_valid & out_ready;
  assign out_valid  = r_out_valid;

  // Next-state, counter and datapath strobe decode.
  always_comb begin
    w_state_next = r_state;
    cnt_next     = r_cnt;
    start        = 1'b0;
    accum        = 1'b0;
    close        = 1'b0;
    clear        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_in_fire) begin
          start        = 1'b1;
          cnt_next     = c_one;
          close        = c_single | flush;
          w_state_next = close ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (w_in_fire) begin
          accum    = 1'b1;
          cnt_next = r_cnt + c_one;
        end
        close = (cnt_next == c_full) | flush;
        if (close) begin
          w_state_next = HOLD;
        end
      end
      HOLD: begin
        if (w_out_fire) begin
          if (w_in_fire) begin
            start        = 1'b1;
            cnt_next     = c_one;
            close        = c_single | flush;
            w_state_next = close ? HOLD : ACCUM;
          end else begin
            clear        = 1'b1;
            cnt_next     = '0;
            w_state_next = IDLE;
          end
        end
      end
      default: begin
        clear        = 1'b1;
        cnt_next     = '0;
        w_state_next = IDLE;
      end
    endcase
  end

  // State, sample counter and registered out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= cnt_next;
      r_out_valid <= (w_state_next == HOLD);
    end
  end

endmodule
`default_nettype wire

// File: rtl/sum_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : sum_accumulator
// Brief    : Accumulates COUNT_N unsigned samples (or fewer on flush) and
//            presents the batch total and sample count on a valid/ready port.
//            Build option SUM_ACCUMULATOR_SAT_EN: saturating accumulation plus
//            a sticky per-batch overflow flag on out_sat. Without it the sum
//            wraps modulo 2^ACC_W and out_sat is absent.
// Revision : 1.0 - initial release
// ============================================================================
module sum_accumulator
  import sum_accumulator_pkg::*;
#(
  parameter int unsigned DATA_W  = C_DATA_W_DEF,
  parameter int unsigned ACC_W   = C_ACC_W_DEF,
  parameter int unsigned COUNT_N = C_COUNT_N_DEF
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [DATA_W-1:0]                in_data,
  input  logic                             flush,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [ACC_W-1:0]                 out_data,
`ifdef SUM_ACCUMULATOR_SAT_EN
  output logic                             out_sat,
`endif
  output logic [$clog2(COUNT_N+1)-1:0]     out_count
);

  localparam int unsigned CNT_W = $clog2(COUNT_N + 1);

  logic             w_start;
  logic             w_accum;
  logic             w_close;
  logic             w_clear;
  logic [CNT_W-1:0] w_cnt_next;

  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_acc_next;
  logic [ACC_W-1:0] w_acc_sum;
  logic [ACC_W-1:0] r_out_data;
  logic [CNT_W-1:0] r_out_count;

  sum_accumulator_ctrl #(
    .COUNT_N (COUNT_N),
    .CNT_W   (CNT_W)
  ) u_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .flush     (flush),
    .out_ready (out_ready),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .start     (w_start),
    .accum     (w_accum),
    .close     (w_close),
    .clear     (w_clear),
    .cnt_next  (w_cnt_next)
  );

`ifdef SUM_ACCUMULATOR_SAT_EN
  sat_res_t w_sat_res;
  logic     r_sat;
  logic     w_sat_next;
  logic     r_out_sat;

  assign w_sat_res = sat_add(C_SAT_W'(r_acc), C_SAT_W'(in_data), ACC_W);
  assign w_acc_sum = ACC_W'(w_sat_res.value);

  // Sticky overflow flag, restarted with every new batch.
  always_comb begin
    w_sat_next = r_sat;
    if (w_clear || w_start) begin
      w_sat_next = 1'b0;
    end else if (w_accum) begin
      w_sat_next = r_sat | w_sat_res.ovf;
    end
  end

  // Overflow flag register and its output copy, captured with the batch total.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sat     <= 1'b0;
      r_out_sat <= 1'b0;
    end else begin
      r_sat <= w_sat_next;
      if (w_close) begin
        r_out_sat <= w_sat_next;
      end
    end
  end

  assign out_sat = r_out_sat;
`else
  assign w_acc_sum = r_acc + ACC_W'(in_data);
`endif

  // Accumulator next value: restart, add, or clear after the result is taken.
  always_comb begin
    w_acc_next = r_acc;
    if (w_clear) begin
      w_acc_next = '0;
    end else if (w_start) begin
      w_acc_next = ACC_W'(in_data);
    end else if (w_accum) begin
      w_acc_next = w_acc_sum;
    end
  end

  // Accumulator and output registers; outputs load the final batch values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_out_data  <= '0;
      r_out_count <= '0;
    end else begin
      r_acc <= w_acc_next;
      if (w_close) begin
        r_out_data  <= w_acc_next;
        r_out_count <= w_cnt_next;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_count = r_out_count;

endmodule
`default_nettype wire

// File: tb/tb_sum_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_sum_accumulator
// Brief    : Self-checking scoreboard bench for sum_accumulator. Expected
//            batch results are queued as stimulus is driven and compared when
//            the DUT hands a result to the sink.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sum_accumulator;

  localparam int DATA_W  = 16;
  localparam int ACC_W   = 18;
  localparam int COUNT_N = 8;
  localparam int CNT_W   = $clog2(COUNT_N + 1);

  logic              clk       = 1'b0;
  logic              rst_n     = 1'b1;
  logic              in_valid  = 1'b0;
  logic [DATA_W-1:0] in_data   = '0;
  logic              flush     = 1'b0;
  logic              out_ready = 1'b0;
  logic              in_ready;
  logic              out_valid;
  logic [ACC_W-1:0]  out_data;
  logic [CNT_W-1:0]  out_count;
`ifdef SUM_ACCUMULATOR_SAT_EN
  logic              out_sat;
`endif

  typedef struct {
    int unsigned data;
    int unsigned count;
    bit          sat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  sum_accumulator #(
    .DATA_W  (DATA_W),
    .ACC_W   (ACC_W),
    .COUNT_N (COUNT_N)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef SUM_ACCUMULATOR_SAT_EN
    .out_sat   (out_sat),
`endif
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic push_exp(input int unsigned d, input int unsigned c, input bit s);
    exp_t e;
    e.data  = d;
    e.count = c;
    e.sat   = s;
    sb.push_back(e);
  endtask

  // Drive one sample (called at posedge+1); returns at posedge+1 after it fires.
  task automatic send(input logic [DATA_W-1:0] d, input logic f);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_data  = d;
    flush    = f;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic send_n(input int n, input logic [DATA_W-1:0] d);
    for (int i = 0; i < n; i++) send(d, 1'b0);
  endtask

  // Scoreboard monitor: compare every result the sink accepts.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("out_data", 32'(out_data), mon_e.data);
        check("out_count", 32'(out_count), mon_e.count);
`ifdef SUM_ACCUMULATOR_SAT_EN
        check("out_sat", 32'(out_sat), 32'(mon_e.sat));
`endif
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #1 rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic batch with latency check
    out_ready = 1'b1;
    push_exp(8000, 8, 1'b0);
    send_n(7, 16'd1000);
    check("lat_before_last", 32'(out_valid), 32'd0);
    send(16'd1000, 1'b0);
    check("lat_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;
    check("idle_after_basic", 32'(out_valid), 32'd0);

    // Backpressure, then zero-bubble restart with sample 7
    out_ready = 1'b0;
    push_exp(40, 8, 1'b0);
    send_n(8, 16'd5);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_data", 32'(out_data), 32'd40);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b1;
    in_data   = 16'd7;
    out_ready = 1'b1;
    push_exp(14, 8, 1'b0);
    @(negedge clk);
    check("restart_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("restart_no_valid", 32'(out_valid), 32'd0);
    send_n(7, 16'd1);
    @(posedge clk);
    #1;

    // Flush with a same-cycle sample
    push_exp(400, 4, 1'b0);
    send_n(3, 16'd100);
    send(16'd100, 1'b1);
    check("flush_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;

    // Flush alone in ACCUM closes the partial batch
    push_exp(100, 2, 1'b0);
    send_n(2, 16'd50);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_alone_accum", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;

    // Flush alone in IDLE produces nothing
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("flush_idle_no_out", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;

    // Overflow
`ifdef SUM_ACCUMULATOR_SAT_EN
    push_exp(262143, 8, 1'b1);
`else
    push_exp(262136, 8, 1'b0);
`endif
    send_n(8, 16'hFFFF);
    @(posedge clk);
    #1;

    // Async reset mid-batch, between clock edges
    send_n(4, 16'd2);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    check("arst_out_data", 32'(out_data), 32'd0);
    check("arst_out_count", 32'(out_count), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    push_exp(16, 8, 1'b0);
    send_n(8, 16'd2);

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
